// File: rtl/edge_mode_cycler.sv
// ---------------------------------------------------------------------------
// edge_mode_cycler
//
// Steps a mode index through NUM_MODES states on qualified edges of a raw
// asynchronous level input. The input is synchronised and debounced, and the
// selected edge of the filtered level steps the mode up or down, wrapping or
// saturating at the ends. Sits between a button/strobe input and mode-select
// consumers.
//
// Ports:
//   clk          clock, all logic on rising edge
//   rst_n        asynchronous active-low reset
//   in           raw asynchronous level input
//   enable       1 = qualified edges step the mode, 0 = edges dropped
//   dir          step direction: 0 up (+1), 1 down (-1)
//   clear        synchronous clear of mode to 0 (highest priority)
//   mode         current mode index, 0..NUM_MODES-1
//   mode_onehot  registered one-hot of mode
//   step_pulse   1-cycle strobe in the first cycle mode shows a stepped value
//   wrap_pulse   1-cycle strobe when that step wrapped end to end
// ---------------------------------------------------------------------------
module edge_mode_cycler #(
   parameter int NUM_MODES       = 3,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int EDGE_SEL        = 0,
   parameter int WRAP            = 1,
   localparam int MW             = $clog2(NUM_MODES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in,
   input  logic                 enable,
   input  logic                 dir,
   input  logic                 clear,
   output logic [MW-1:0]        mode,
   output logic [NUM_MODES-1:0] mode_onehot,
   output logic                 step_pulse,
   output logic                 wrap_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [CW-1:0]          cnt;
   logic                   filt;
   logic                   filt_d;
   logic                   rise;
   logic                   fall;
   logic                   qual_edge;

   logic [MW-1:0]          mode_nx;
   logic [NUM_MODES-1:0]   onehot_nx;
   logic                   step_nx;
   logic                   wrap_nx;

   // ------------------------------------------------------------------------
   // Synchroniser, debounce filter and edge delay register
   // ------------------------------------------------------------------------
   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= '0;
         cnt    <= '0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], in};
         filt_d <= filt;
         // filt only follows s after DEBOUNCE_CYCLES consecutive disagreeing
         // samples; any agreement restarts the count.
         if (s == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filt <= s;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign rise = filt & ~filt_d;
   assign fall = ~filt & filt_d;

   always_comb begin
      case (EDGE_SEL)
         0:       qual_edge = rise;
         1:       qual_edge = fall;
         default: qual_edge = rise | fall;
      endcase
   end

   // ------------------------------------------------------------------------
   // Mode next-state and strobes
   // ------------------------------------------------------------------------
   always_comb begin
      mode_nx = mode;
      step_nx = 1'b0;
      wrap_nx = 1'b0;
      if (clear) begin
         mode_nx = '0;
      end else if (qual_edge && enable) begin
         if (!dir) begin
            if (mode != LAST_MODE) begin
               mode_nx = mode + MW'(1);
               step_nx = 1'b1;
            end else if (WRAP != 0) begin
               mode_nx = '0;
               step_nx = 1'b1;
               wrap_nx = 1'b1;
            end
         end else begin
            if (mode != '0) begin
               mode_nx = mode - MW'(1);
               step_nx = 1'b1;
            end else if (WRAP != 0) begin
               mode_nx = LAST_MODE;
               step_nx = 1'b1;
               wrap_nx = 1'b1;
            end
         end
      end
      onehot_nx          = '0;
      onehot_nx[mode_nx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode        <= '0;
         mode_onehot <= NUM_MODES'(1);
         step_pulse  <= 1'b0;
         wrap_pulse  <= 1'b0;
      end else begin
         mode        <= mode_nx;
         mode_onehot <= onehot_nx;
         step_pulse  <= step_nx;
         wrap_pulse  <= wrap_nx;
      end
   end

endmodule

// File: tb/tb_edge_mode_cycler.sv
// ---------------------------------------------------------------------------
// tb_edge_mode_cycler
//
// Three instances share the clock and reset:
//   dut_a  defaults (3 modes, rising edge, wrap)
//   dut_b  WRAP=0 (saturating)
//   dut_c  NUM_MODES=5, EDGE_SEL=2 (both edges)
// Pulse vectors come from a table; latency, clear-vs-edge and reset corner
// cases are hand-written sequences on dut_a.
// ---------------------------------------------------------------------------
module tb_edge_mode_cycler;

   logic clk;
   logic rst_n;
   logic in_v     [3];
   logic enable_v [3];
   logic dir_v    [3];
   logic clear_v  [3];

   logic [1:0] mode_a;
   logic [2:0] oh_a;
   logic       step_a, wrap_a;
   logic [1:0] mode_b;
   logic [2:0] oh_b;
   logic       step_b, wrap_b;
   logic [2:0] mode_c;
   logic [4:0] oh_c;
   logic       step_c, wrap_c;

   int checks = 0;
   int errors = 0;
   int steps     [3] = '{0, 0, 0};
   int wraps     [3] = '{0, 0, 0};
   int bad_wrap  = 0;
   int bad_oh    = 0;

   edge_mode_cycler dut_a (
      .clk(clk), .rst_n(rst_n), .in(in_v[0]), .enable(enable_v[0]),
      .dir(dir_v[0]), .clear(clear_v[0]), .mode(mode_a),
      .mode_onehot(oh_a), .step_pulse(step_a), .wrap_pulse(wrap_a));

   edge_mode_cycler #(.WRAP(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in(in_v[1]), .enable(enable_v[1]),
      .dir(dir_v[1]), .clear(clear_v[1]), .mode(mode_b),
      .mode_onehot(oh_b), .step_pulse(step_b), .wrap_pulse(wrap_b));

   edge_mode_cycler #(.NUM_MODES(5), .EDGE_SEL(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .in(in_v[2]), .enable(enable_v[2]),
      .dir(dir_v[2]), .clear(clear_v[2]), .mode(mode_c),
      .mode_onehot(oh_c), .step_pulse(step_c), .wrap_pulse(wrap_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe counters and structural invariants, sampled away from posedge.
   always @(negedge clk) begin
      if (step_a) steps[0]++;
      if (step_b) steps[1]++;
      if (step_c) steps[2]++;
      if (wrap_a) wraps[0]++;
      if (wrap_b) wraps[1]++;
      if (wrap_c) wraps[2]++;
      if ((wrap_a && !step_a) || (wrap_b && !step_b) || (wrap_c && !step_c))
         bad_wrap++;
      if ($countones(oh_a) != 1 || oh_a[mode_a] != 1'b1) bad_oh++;
      if ($countones(oh_b) != 1 || oh_b[mode_b] != 1'b1) bad_oh++;
      if ($countones(oh_c) != 1 || mode_c > 3'd4 || oh_c[mode_c] != 1'b1) bad_oh++;
   end

   function automatic int mode_of(input int d);
      case (d)
         0:       return int'(mode_a);
         1:       return int'(mode_b);
         default: return int'(mode_c);
      endcase
   endfunction

   function automatic int oh_of(input int d);
      case (d)
         0:       return int'(oh_a);
         1:       return int'(oh_b);
         default: return int'(oh_c);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One high pulse of hi cycles on instance d, then a long low tail so both
   // the rising and falling filtered edges have settled.
   task automatic pulse(input int d, input int hi, input logic en, input logic dr);
      @(negedge clk);
      enable_v[d] = en;
      dir_v[d]    = dr;
      in_v[d]     = 1'b1;
      repeat (hi) @(negedge clk);
      in_v[d] = 1'b0;
      repeat (25) @(negedge clk);
   endtask

   typedef struct packed {
      int   dut;
      int   hi;
      logic en;
      logic dr;
      int   exp_mode;
      int   exp_steps;
      int   exp_wraps;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs [NVEC];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int s0, w0, lat, step_next;

      // dut, hi, en, dir, mode, steps, wraps
      vecs[0]  = '{0, 20, 1'b1, 1'b0, 1, 1, 0};
      vecs[1]  = '{0, 20, 1'b1, 1'b0, 2, 1, 0};
      vecs[2]  = '{0, 20, 1'b1, 1'b0, 0, 1, 1};
      vecs[3]  = '{0,  3, 1'b1, 1'b0, 0, 0, 0};   // glitch filtered
      vecs[4]  = '{0,  4, 1'b1, 1'b0, 1, 1, 0};   // just long enough
      vecs[5]  = '{0, 20, 1'b1, 1'b1, 0, 1, 0};
      vecs[6]  = '{0, 20, 1'b1, 1'b1, 2, 1, 1};   // down-wrap 0 -> 2
      vecs[7]  = '{0, 20, 1'b0, 1'b0, 2, 0, 0};   // disabled
      vecs[8]  = '{0, 20, 1'b0, 1'b0, 2, 0, 0};
      vecs[9]  = '{1, 20, 1'b1, 1'b1, 0, 0, 0};   // saturate at 0
      vecs[10] = '{1, 20, 1'b1, 1'b0, 1, 1, 0};
      vecs[11] = '{1, 20, 1'b1, 1'b0, 2, 1, 0};
      vecs[12] = '{1, 20, 1'b1, 1'b0, 2, 0, 0};   // saturate at top
      vecs[13] = '{2, 20, 1'b1, 1'b0, 2, 2, 0};   // rise and fall both step
      vecs[14] = '{2, 20, 1'b1, 1'b1, 0, 2, 0};
      vecs[15] = '{2, 20, 1'b1, 1'b1, 3, 2, 1};   // 0 -> 4 (wrap) -> 3

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         in_v[d] = 1'b0; enable_v[d] = 1'b1; dir_v[d] = 1'b0; clear_v[d] = 1'b0;
      end
      #13;
      check("reset_mode_a", int'(mode_a), 0);
      check("reset_onehot_a", int'(oh_a), 1);
      check("reset_step_a", int'(step_a), 0);
      check("reset_wrap_a", int'(wrap_a), 0);
      check("reset_onehot_c", int'(oh_c), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // ---- table-driven pulse vectors ----
      for (int i = 0; i < NVEC; i++) begin
         s0 = steps[vecs[i].dut];
         w0 = wraps[vecs[i].dut];
         pulse(vecs[i].dut, vecs[i].hi, vecs[i].en, vecs[i].dr);
         check($sformatf("vec%0d_mode", i), mode_of(vecs[i].dut), vecs[i].exp_mode);
         check($sformatf("vec%0d_onehot", i), oh_of(vecs[i].dut), 1 << vecs[i].exp_mode);
         check($sformatf("vec%0d_steps", i), steps[vecs[i].dut] - s0, vecs[i].exp_steps);
         check($sformatf("vec%0d_wraps", i), wraps[vecs[i].dut] - w0, vecs[i].exp_wraps);
      end

      // ---- clear coinciding with a qualified edge at mode 2 ----
      s0 = steps[0];
      @(negedge clk);
      enable_v[0] = 1'b1; dir_v[0] = 1'b0; in_v[0] = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("clr_pre_mode", int'(mode_a), 2);
      @(negedge clk);
      clear_v[0] = 1'b1;
      @(posedge clk);
      #1;
      check("clr_mode", int'(mode_a), 0);
      check("clr_onehot", int'(oh_a), 1);
      check("clr_step", int'(step_a), 0);
      check("clr_wrap", int'(wrap_a), 0);
      @(negedge clk);
      clear_v[0] = 1'b0;
      repeat (14) @(negedge clk);
      in_v[0] = 1'b0;
      repeat (25) @(negedge clk);
      check("clr_after_mode", int'(mode_a), 0);
      check("clr_after_steps", steps[0] - s0, 0);

      // ---- latency from in rising to mode change, and strobe width ----
      lat = 0;
      step_next = -1;
      @(negedge clk);
      in_v[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (lat != 0 && k == lat + 1) step_next = int'(step_a);
         if (lat == 0 && mode_a != 2'd0) begin
            lat = k;
            check("lat_step_on_change", int'(step_a), 1);
            check("lat_wrap_on_change", int'(wrap_a), 0);
         end
      end
      check("lat_edges", lat, 7);
      check("lat_step_one_cycle", step_next, 0);
      @(negedge clk);
      in_v[0] = 1'b0;
      repeat (25) @(negedge clk);
      check("lat_mode", int'(mode_a), 1);
      check("lat_onehot", int'(oh_a), 2);

      pulse(0, 20, 1'b1, 1'b0);
      check("pre_rst_mode", int'(mode_a), 2);

      // ---- asynchronous reset mid-debounce ----
      s0 = steps[0];
      @(negedge clk);
      in_v[0] = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_mode", int'(mode_a), 0);
      check("arst_onehot", int'(oh_a), 1);
      check("arst_step", int'(step_a), 0);
      check("arst_wrap", int'(wrap_a), 0);
      in_v[0] = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("arst_after_mode", int'(mode_a), 0);
      check("arst_after_steps", steps[0] - s0, 0);

      // ---- in held high through reset release counts as a rising edge ----
      s0 = steps[0];
      @(negedge clk);
      in_v[0] = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("held_mode", int'(mode_a), 1);
      check("held_steps", steps[0] - s0, 1);
      in_v[0] = 1'b0;
      repeat (25) @(negedge clk);

      check("wrap_only_with_step", bad_wrap, 0);
      check("onehot_invariant", bad_oh, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
